id_ex_stage: RTL and testbench

- Decode-to-execute boundary of the 5-stage pipeline; sits directly downstream of the register file.
- Takes the register file read data, adds the write-back bypass the register file lacks (write lands on posedge, read is combinational), and detects load-use hazards.
- Owns the ID/EX pipeline register with flush/hold.
- Sequences interrupt entry by driving the register file's IRQ save (IRQWrite/PC) and bubbling the interrupted instruction.

---
 rtl/id_ex_stage.sv | 130 +++++++++++++
 tb/tb_id_ex_stage.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX boundary: write-back bypass onto register file read data, load-use hazard
// detection, interrupt-entry sequencing and the ID/EX pipeline register.
module id_ex_stage #(
    parameter int CTRL_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [31:0]       id_pc,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic [4:0]        id_w,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic [31:0]       id_rdata1,
    input  logic [31:0]       id_rdata2,
    input  logic [31:0]       id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              wb_reg_write,
    input  logic [4:0]        wb_w,
    input  logic [31:0]       wb_wdata,
    input  logic              flush,
    input  logic              hold,
    input  logic              irq,
    output logic              stall_id,
    output logic              irq_write,
    output logic [31:0]       irq_pc,
    output logic              ex_valid,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic [31:0]       ex_pc,
    output logic [31:0]       ex_a,
    output logic [31:0]       ex_b,
    output logic [31:0]       ex_imm,
    output logic [4:0]        ex_w,
    output logic [4:0]        ex_rs,
    output logic [4:0]        ex_rt,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [CNT_W-1:0]  lu_stall_cnt
);

    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        load_use;
    logic        irq_take;
    logic        load_en;
    logic        bubble;
    logic        cnt_inc;

    // Register file writes land on the clock edge, so a same-cycle WB write must be bypassed here.
    always_comb begin
        op_a = id_rdata1;
        if (id_rs == 5'd0)
            op_a = 32'd0;
        else if (wb_reg_write && (wb_w == id_rs))
            op_a = wb_wdata;
    end

    always_comb begin
        op_b = id_rdata2;
        if (id_rt == 5'd0)
            op_b = 32'd0;
        else if (wb_reg_write && (wb_w == id_rt))
            op_b = wb_wdata;
    end

    assign load_use = id_valid & ex_valid & ex_mem_read & (ex_w != 5'd0) &
                      ((id_use_rs & (ex_w == id_rs)) | (id_use_rt & (ex_w == id_rt)));
    assign irq_take = irq & id_valid & ~flush & ~hold;

    assign irq_write = irq_take;
    assign irq_pc    = id_pc;
    assign stall_id  = hold | (load_use & ~irq_take & ~flush);

    // Flush overrides hold; otherwise hold freezes the register entirely.
    assign load_en = flush | ~hold;
    assign bubble  = flush | irq_take | load_use;
    assign cnt_inc = ~flush & ~hold & ~irq_take & load_use;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_valid     <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_pc        <= '0;
            ex_a         <= '0;
            ex_b         <= '0;
            ex_imm       <= '0;
            ex_w         <= '0;
            ex_rs        <= '0;
            ex_rt        <= '0;
            ex_ctrl      <= '0;
            lu_stall_cnt <= '0;
        end else begin
            if (load_en) begin
                if (bubble) begin
                    ex_valid     <= 1'b0;
                    ex_reg_write <= 1'b0;
                    ex_mem_read  <= 1'b0;
                    ex_pc        <= '0;
                    ex_a         <= '0;
                    ex_b         <= '0;
                    ex_imm       <= '0;
                    ex_w         <= '0;
                    ex_rs        <= '0;
                    ex_rt        <= '0;
                    ex_ctrl      <= '0;
                end else begin
                    ex_valid     <= id_valid;
                    ex_reg_write <= id_reg_write & id_valid;
                    ex_mem_read  <= id_mem_read & id_valid;
                    ex_pc        <= id_pc;
                    ex_a         <= op_a;
                    ex_b         <= op_b;
                    ex_imm       <= id_imm;
                    ex_w         <= id_w;
                    ex_rs        <= id_rs;
                    ex_rt        <= id_rt;
                    ex_ctrl      <= id_ctrl;
                end
            end
            if (cnt_inc && (lu_stall_cnt != {CNT_W{1'b1}}))
                lu_stall_cnt <= lu_stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage; a second instance with a 2-bit
// stall counter shares all inputs to exercise counter saturation.
module tb_id_ex_stage;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [4:0]  id_rs, id_rt, id_w;
    logic        id_use_rs, id_use_rt, id_reg_write, id_mem_read;
    logic [31:0] id_rdata1, id_rdata2, id_imm;
    logic [15:0] id_ctrl;
    logic        wb_reg_write;
    logic [4:0]  wb_w;
    logic [31:0] wb_wdata;
    logic        flush, hold, irq;

    logic        stall_id, irq_write;
    logic [31:0] irq_pc;
    logic        ex_valid, ex_reg_write, ex_mem_read;
    logic [31:0] ex_pc, ex_a, ex_b, ex_imm;
    logic [4:0]  ex_w, ex_rs, ex_rt;
    logic [15:0] ex_ctrl;
    logic [15:0] lu_stall_cnt;

    logic        s_stall_id, s_irq_write;
    logic [31:0] s_irq_pc;
    logic        s_ex_valid, s_ex_reg_write, s_ex_mem_read;
    logic [31:0] s_ex_pc, s_ex_a, s_ex_b, s_ex_imm;
    logic [4:0]  s_ex_w, s_ex_rs, s_ex_rt;
    logic [15:0] s_ex_ctrl;
    logic [1:0]  s_cnt;

    int errors = 0;
    int checks = 0;

    id_ex_stage #(.CTRL_W(16), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_w(id_w), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm), .id_ctrl(id_ctrl),
        .wb_reg_write(wb_reg_write), .wb_w(wb_w), .wb_wdata(wb_wdata),
        .flush(flush), .hold(hold), .irq(irq),
        .stall_id(stall_id), .irq_write(irq_write), .irq_pc(irq_pc),
        .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_pc(ex_pc), .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm),
        .ex_w(ex_w), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_ctrl(ex_ctrl),
        .lu_stall_cnt(lu_stall_cnt)
    );

    id_ex_stage #(.CTRL_W(16), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_w(id_w), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm), .id_ctrl(id_ctrl),
        .wb_reg_write(wb_reg_write), .wb_w(wb_w), .wb_wdata(wb_wdata),
        .flush(flush), .hold(hold), .irq(irq),
        .stall_id(s_stall_id), .irq_write(s_irq_write), .irq_pc(s_irq_pc),
        .ex_valid(s_ex_valid), .ex_reg_write(s_ex_reg_write), .ex_mem_read(s_ex_mem_read),
        .ex_pc(s_ex_pc), .ex_a(s_ex_a), .ex_b(s_ex_b), .ex_imm(s_ex_imm),
        .ex_w(s_ex_w), .ex_rs(s_ex_rs), .ex_rt(s_ex_rt), .ex_ctrl(s_ex_ctrl),
        .lu_stall_cnt(s_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [31:0] pc, input logic [4:0] rs, input logic [4:0] rt,
                             input logic urs, input logic urt, input logic [4:0] w,
                             input logic rw, input logic mr);
        id_valid     = 1'b1;
        id_pc        = pc;
        id_rs        = rs;
        id_rt        = rt;
        id_use_rs    = urs;
        id_use_rt    = urt;
        id_w         = w;
        id_reg_write = rw;
        id_mem_read  = mr;
    endtask

    initial begin
        rst = 1'b1;
        id_valid = 0; id_pc = 0; id_rs = 0; id_rt = 0; id_w = 0;
        id_use_rs = 0; id_use_rt = 0; id_reg_write = 0; id_mem_read = 0;
        id_rdata1 = 0; id_rdata2 = 0; id_imm = 0; id_ctrl = 0;
        wb_reg_write = 0; wb_w = 0; wb_wdata = 0;
        flush = 0; hold = 0; irq = 0;

        #2 rst = 1'b0;
        #1;
        chk("rst_ex_valid", ex_valid, 0);
        chk("rst_cnt", lu_stall_cnt, 0);
        chk("rst_stall_id", stall_id, 0);
        chk("rst_irq_write", irq_write, 0);
        @(negedge clk);
        rst = 1'b1;

        // WB bypass onto rs
        set_instr(32'h100, 5'd5, 5'd6, 1, 1, 5'd9, 1, 0);
        id_rdata1 = 32'h11111111; id_rdata2 = 32'h22222222;
        id_imm = 32'h44; id_ctrl = 16'hABCD;
        wb_reg_write = 1; wb_w = 5'd5; wb_wdata = 32'hDEADBEEF;
        tick();
        chk("byp_ex_a", ex_a, 32'hDEADBEEF);
        chk("byp_ex_b", ex_b, 32'h22222222);
        chk("byp_ex_valid", ex_valid, 1);
        chk("byp_ex_w", ex_w, 9);
        chk("byp_ex_pc", ex_pc, 32'h100);
        chk("byp_ex_ctrl", ex_ctrl, 16'hABCD);
        chk("byp_ex_imm", ex_imm, 32'h44);
        chk("byp_ex_reg_write", ex_reg_write, 1);

        // Register 0 always reads zero, even when WB targets it
        id_rs = 5'd0; wb_w = 5'd0;
        tick();
        chk("r0_ex_a", ex_a, 0);
        wb_reg_write = 0;

        // Asynchronous reset while EX holds a valid instruction
        chk("pre_rst_valid", ex_valid, 1);
        rst = 1'b0;
        #1;
        chk("async_rst_valid", ex_valid, 0);
        chk("async_rst_ex_b", ex_b, 0);
        chk("async_rst_ex_pc", ex_pc, 0);
        chk("async_rst_cnt", lu_stall_cnt, 0);
        rst = 1'b1;
        tick();
        chk("post_rst_capture", ex_valid, 1);

        // Load-use: lw $8 then add reading $8
        set_instr(32'h200, 5'd1, 5'd0, 1, 0, 5'd8, 1, 1);
        tick();
        chk("lw_ex_mem_read", ex_mem_read, 1);
        set_instr(32'h204, 5'd8, 5'd2, 1, 1, 5'd10, 1, 0);
        #1;
        chk("lu_stall_id", stall_id, 1);
        tick();
        chk("lu_bubble", ex_valid, 0);
        chk("lu_cnt1", lu_stall_cnt, 1);
        chk("lu_stall_released", stall_id, 0);
        tick();
        chk("lu_consumer_valid", ex_valid, 1);
        chk("lu_consumer_w", ex_w, 10);
        chk("lu_consumer_rs", ex_rs, 8);

        // Same pair but consumer does not read rs
        set_instr(32'h208, 5'd1, 5'd0, 1, 0, 5'd8, 1, 1);
        tick();
        set_instr(32'h20C, 5'd8, 5'd2, 0, 1, 5'd10, 1, 0);
        #1;
        chk("no_use_rs_stall", stall_id, 0);
        tick();
        chk("no_use_rs_capture", ex_valid, 1);
        chk("no_use_rs_cnt", lu_stall_cnt, 1);

        // Load targeting $0 never stalls
        set_instr(32'h210, 5'd1, 5'd0, 1, 0, 5'd0, 1, 1);
        tick();
        set_instr(32'h214, 5'd0, 5'd0, 1, 1, 5'd10, 1, 0);
        #1;
        chk("w0_load_stall", stall_id, 0);

        // IRQ with load-use also pending
        set_instr(32'h218, 5'd1, 5'd0, 1, 0, 5'd8, 1, 1);
        tick();
        set_instr(32'h00400010, 5'd8, 5'd2, 1, 1, 5'd11, 1, 0);
        irq = 1;
        #1;
        chk("irq_write", irq_write, 1);
        chk("irq_pc", irq_pc, 32'h00400010);
        chk("irq_over_lu_stall", stall_id, 0);
        tick();
        chk("irq_bubble", ex_valid, 0);
        chk("irq_no_cnt", lu_stall_cnt, 1);
        irq = 0;
        #1;
        chk("irq_write_drop", irq_write, 0);

        // Flush + hold + irq together
        set_instr(32'h300, 5'd3, 5'd4, 1, 1, 5'd12, 1, 0);
        tick();
        chk("pre_flush_valid", ex_valid, 1);
        flush = 1; hold = 1; irq = 1;
        #1;
        chk("flush_irq_write", irq_write, 0);
        chk("flush_hold_stall", stall_id, 1);
        tick();
        chk("flush_hold_bubble", ex_valid, 0);
        flush = 0; hold = 0; irq = 0;

        // Hold for 3 cycles with a load-use pending underneath
        set_instr(32'h400, 5'd1, 5'd0, 1, 0, 5'd8, 1, 1);
        tick();
        set_instr(32'h404, 5'd8, 5'd2, 1, 1, 5'd13, 1, 0);
        hold = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("hold_stall_id", stall_id, 1);
            tick();
            chk("hold_ex_pc", ex_pc, 32'h400);
            chk("hold_ex_mem_read", ex_mem_read, 1);
        end
        chk("hold_cnt", lu_stall_cnt, 1);
        hold = 0;
        tick();
        chk("post_hold_bubble", ex_valid, 0);
        chk("post_hold_cnt", lu_stall_cnt, 2);
        chk("post_hold_sat_cnt", s_cnt, 2);
        tick();
        chk("post_hold_capture_pc", ex_pc, 32'h404);

        // Three more load-use events: 2-bit counter saturates at 3
        for (int i = 0; i < 3; i++) begin
            set_instr(32'h500, 5'd1, 5'd0, 1, 0, 5'd8, 1, 1);
            tick();
            set_instr(32'h504, 5'd2, 5'd8, 0, 1, 5'd14, 1, 0);
            tick();
            chk("sat_bubble", s_ex_valid, 0);
            chk("sat_cnt2", s_cnt, (i == 0) ? 3 : 3);
        end
        chk("cnt16_total", lu_stall_cnt, 5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
